// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one stop bit of SB_TICK ticks.
// Emits a one-cycle rx_done_tick with the byte, or a one-cycle o_frame_err
// when the stop bit samples low.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] rx_data_out,
    output logic            o_frame_err
);

    localparam int unsigned   NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] NLast   = NW'(DBIT - 1);
    localparam logic [3:0]    SMid    = 4'd7;
    localparam logic [3:0]    SBitEnd = 4'd15;
    localparam logic [3:0]    SStop   = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [3:0]        s_cnt_q, s_cnt_d;
    logic [NW-1:0]     n_cnt_q, n_cnt_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [DBIT-1:0]   data_q, data_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              rx_meta_q, rx_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta_q <= 1'b1;
            rx_q      <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_q      <= rx_meta_q;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic; without s_tick every non-idle state holds.
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_q) begin
                    state_d = StStart;
                    s_cnt_d = '0;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_cnt_q == SMid) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (!rx_q) begin
                            state_d = StData;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_cnt_q == SBitEnd) begin
                        s_cnt_d = '0;
                        b_d     = {rx_q, b_q[DBIT-1:1]};
                        if (n_cnt_q == NLast) begin
                            state_d = StStop;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (s_cnt_q == SStop) begin
                        state_d = StIdle;
                        if (rx_q) begin
                            data_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_done_tick = done_q;
    assign o_frame_err  = ferr_q;
    assign rx_data_out  = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven tick-aligned, and a
// queue of expected events (byte or framing error) is derived from the
// frames themselves and checked by a per-cycle compare process.
module tb_uart_rx;

    logic       i_clk;
    logic       i_reset;
    logic       i_rx;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] rx_data_out;
    logic       o_frame_err;

    int         total;
    int         bad;
    int         wr;
    int         rd;
    bit         exp_err  [256];
    logic [7:0] exp_data [256];
    logic [7:0] model_data;
    logic [7:0] last_good;
    int         tick_div;
    bit         tick_en;
    int         tcnt;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .s_tick      (s_tick),
        .rx_done_tick(rx_done_tick),
        .rx_data_out (rx_data_out),
        .o_frame_err (o_frame_err)
    );

    // 50 MHz clock.
    initial begin
        i_clk = 1'b0;
        forever #10 i_clk = ~i_clk;
    end

    // Baud tick generator: one-cycle pulse every tick_div cycles, gated by tick_en.
    initial begin
        s_tick = 1'b0;
        tcnt   = 0;
        forever begin
            @(negedge i_clk);
            if (tick_en && tcnt >= tick_div - 1) begin
                tcnt   = 0;
                s_tick = 1'b1;
            end else begin
                if (tick_en) tcnt++;
                s_tick = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Per-cycle compare against the expected-event queue.
    initial begin
        rd         = 0;
        model_data = 8'h00;
        forever begin
            @(negedge i_clk);
            if (!i_reset) begin
                rd         = wr;
                model_data = 8'h00;
            end else begin
                if (rx_done_tick || o_frame_err) begin
                    if (rd == wr) begin
                        check("spurious_pulse", 32'({rx_done_tick, o_frame_err}), 32'd0);
                    end else begin
                        check("pulse_kind", 32'({rx_done_tick, o_frame_err}),
                              exp_err[rd % 256] ? 32'd1 : 32'd2);
                        if (!exp_err[rd % 256]) model_data = exp_data[rd % 256];
                        rd++;
                    end
                end
                check("data_out", 32'(rx_data_out), 32'(model_data));
            end
        end
    end

    // Wait for n tick pulses, then move to the following negedge to drive.
    task automatic wait_ticks(input int n);
        int cnt;
        repeat (n) begin
            cnt = 0;
            do begin
                @(posedge i_clk);
                cnt++;
            end while (!s_tick && cnt < 2000);
            if (!s_tick) begin
                bad++;
                total++;
                $display("FAIL tick_timeout: got no tick expected tick within 2000 cycles");
                $fatal(1, "tick generator stalled");
            end
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        #1;
        check("rst_done", 32'(rx_done_tick), 32'd0);
        check("rst_ferr", 32'(o_frame_err), 32'd0);
        check("rst_data", 32'(rx_data_out), 32'd0);
        repeat (3) @(negedge i_clk);
        i_reset   = 1'b1;
        i_rx      = 1'b1;
        last_good = 8'h00;
    endtask

    // One 8N1 frame. stop_ok=0 drives the stop bit low for 12 ticks.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int stall_bit, input int abort_bit);
        exp_err[wr % 256]  = !stop_ok;
        exp_data[wr % 256] = d;
        wr++;
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            if (i == abort_bit) begin
                wait_ticks(8);
                do_reset();
                return;
            end
            if (i == stall_bit) begin
                wait_ticks(8);
                tick_en = 1'b0;
                repeat (1000) @(negedge i_clk);
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        if (stop_ok) begin
            i_rx = 1'b1;
            wait_ticks(16);
            last_good = d;
        end else begin
            i_rx = 1'b0;
            wait_ticks(12);
            i_rx = 1'b1;
            wait_ticks(4);
        end
        check("pending_events", 32'(wr - rd), 32'd0);
    endtask

    initial begin
        logic [7:0] byte_v;
        bit         ok;
        total     = 0;
        bad       = 0;
        wr        = 0;
        last_good = 8'h00;
        tick_div  = 163;
        tick_en   = 1'b1;
        i_rx      = 1'b1;
        i_reset   = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        check("reset_done", 32'(rx_done_tick), 32'd0);
        check("reset_ferr", 32'(o_frame_err), 32'd0);
        check("reset_data", 32'(rx_data_out), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;

        // Valid frame at the real baud tick rate.
        wait_ticks(2);
        send_frame(8'hA5, 1'b1, -1, -1);
        check("a5_data", 32'(rx_data_out), 32'hA5);

        tick_div = 5;
        wait_ticks(2);

        // Start-bit glitch: low for 4 ticks only.
        i_rx = 1'b0;
        wait_ticks(4);
        i_rx = 1'b1;
        wait_ticks(12);
        check("glitch_data", 32'(rx_data_out), 32'hA5);
        check("glitch_pending", 32'(wr - rd), 32'd0);

        // Framing error keeps the previous byte.
        send_frame(8'h5A, 1'b1, -1, -1);
        check("5a_data", 32'(rx_data_out), 32'h5A);
        send_frame(8'h3C, 1'b0, -1, -1);
        wait_ticks(16);
        check("ferr_data", 32'(rx_data_out), 32'h5A);

        // Reset during data bit 4, then a fresh frame.
        send_frame(8'hFF, 1'b1, -1, 4);
        wait_ticks(20);
        check("post_rst_data", 32'(rx_data_out), 32'h00);
        send_frame(8'h81, 1'b1, -1, -1);
        check("81_data", 32'(rx_data_out), 32'h81);

        // Back-to-back, no idle gap.
        send_frame(8'h03, 1'b1, -1, -1);
        send_frame(8'h01, 1'b1, -1, -1);
        send_frame(8'h20, 1'b1, -1, -1);
        check("b2b_data", 32'(rx_data_out), 32'h20);

        // Tick stall in the middle of data bit 3.
        send_frame(8'h96, 1'b1, 3, -1);
        check("stall_data", 32'(rx_data_out), 32'h96);

        // Randomized frames, some with a bad stop bit.
        for (int k = 0; k < 25; k++) begin
            byte_v = 8'($urandom);
            ok     = ($urandom_range(0, 4) != 0);
            send_frame(byte_v, ok, -1, -1);
            if (!ok) wait_ticks(16);
            else     wait_ticks(int'($urandom_range(0, 3)));
            check("rand_data", 32'(rx_data_out), 32'(last_good));
        end

        wait_ticks(4);
        check("final_pending", 32'(wr - rd), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, oversampling ticks for the stop bit.
REQ-003 SHALL have port i_clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset, input, 1; one clock; reset is asynchronous and active-low (i_reset = 0 resets).
REQ-005 SHALL have port i_rx, input, 1, serial line, idle high, asynchronous to i_clk.
REQ-006 SHALL have port s_tick, input, 1, one-i_clk-wide pulse at 16x baud rate from the baud generator.
REQ-007 SHALL have port rx_done_tick, output, 1, one-cycle pulse marking a valid received byte.
REQ-008 SHALL have port rx_data_out, output, DBIT, last validly received byte.
REQ-009 SHALL have port o_frame_err, output, 1, one-cycle pulse marking a stop-bit error.

Function
REQ-010 SHALL pass i_rx through a two-flop synchronizer (reset value 1); all references to "rx" below mean the synchronized value.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, with tick counter s_cnt (4 bits), bit counter n_cnt (ceil(log2 DBIT) bits) and shift register b_reg (DBIT bits).
REQ-012 IDLE: rx = 0 -> START, s_cnt = 0; otherwise remain; s_tick ignored.
REQ-013 START: on s_tick with s_cnt = 7 (mid start bit): rx = 0 -> DATA, s_cnt = 0, n_cnt = 0; rx = 1 -> IDLE (glitch rejected, no outputs asserted).
REQ-014 START: on s_tick with s_cnt < 7 -> s_cnt + 1.
REQ-015 DATA: on s_tick with s_cnt = 15 -> s_cnt = 0, b_reg = {rx, b_reg[DBIT-1:1]} (LSB first); n_cnt = DBIT-1 -> STOP, else n_cnt + 1.
REQ-016 DATA: on s_tick with s_cnt < 15 -> s_cnt + 1.
REQ-017 STOP: on s_tick with s_cnt = SB_TICK-1 -> IDLE; rx = 1 -> rx_data_out = b_reg and rx_done_tick = 1 next cycle; rx = 0 -> o_frame_err = 1 next cycle, rx_data_out unchanged.
REQ-018 STOP: on s_tick with s_cnt < SB_TICK-1 -> s_cnt + 1.
REQ-019 In START/DATA/STOP, cycles without s_tick SHALL leave state, counters and b_reg unchanged.
REQ-020 rx_done_tick and o_frame_err SHALL be registered, high exactly one i_clk cycle per frame, never both high together.
REQ-021 rx_data_out SHALL be registered and change only together with rx_done_tick.
REQ-022 Back-to-back frames: rx = 0 on the first IDLE cycle after STOP SHALL enter START on that cycle; no frame lost.
REQ-023 Counters SHALL never wrap; every terminal value forces a defined transition.
REQ-024 Consumer (interface_circuit) samples rx_data_out on the rx_done_tick cycle; rx_data_out SHALL hold until the next valid frame.

Reset
REQ-025 i_reset = 0 SHALL immediately force state = IDLE, s_cnt = 0, n_cnt = 0, b_reg = 0, rx_data_out = 0, rx_done_tick = 0, o_frame_err = 0, synchronizer flops = 1.
REQ-026 Reset mid-frame SHALL discard the partial byte; after release the block waits in IDLE for a fresh falling edge.

Verification
REQ-027 Valid frame: 50 MHz clock, s_tick every 163 cycles, send 0xA5 8N1 -> one rx_done_tick pulse, rx_data_out = 0xA5, o_frame_err = 0.
REQ-028 Glitch: i_rx low for 4 s_tick periods then high -> return to IDLE, no rx_done_tick, rx_data_out unchanged.
REQ-029 Framing error: after 0x5A received, send 0x3C with stop bit = 0 -> one o_frame_err pulse, no rx_done_tick, rx_data_out stays 0x5A.
REQ-030 Reset mid-frame: assert i_reset = 0 during data bit 4 of 0xFF -> outputs 0 immediately; after release, send 0x81 -> rx_data_out = 0x81.
REQ-031 Back-to-back: 0x03, 0x01, 0x20 with no idle gap -> exactly three rx_done_tick pulses carrying 0x03, 0x01, 0x20 in order.
REQ-032 Stall: hold s_tick = 0 for 1000 cycles mid-DATA, then resume -> byte 0x96 still received correctly.
